// File: rtl/layer_code_if.sv
// Pixel byte stream into the NeoPixel serializer: valid/ready handshake with a frame-last flag.
interface layer_code_if;
  logic       data_valid_in;
  logic       data_last_in;
  logic [7:0] data_in;
  logic       data_ready_out;

  modport master (output data_valid_in, data_last_in, data_in, input data_ready_out);
  modport slave  (input data_valid_in, data_last_in, data_in, output data_ready_out);
endinterface

// File: rtl/layer_code.sv
// NeoPixel single-wire serializer: MSB-first high/low phase encoding with a latch period
// after the frame's last byte.
//
// state | meaning
// IDLE  | line low, ready for a byte
// HIGH  | high phase of the current bit
// LOW   | low phase of the current bit
// LATCH | reset/latch low period after the last byte
module layer_code #(
  parameter int unsigned RST_CNT = 4000
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [7:0]    t0h_cnt_in,
  input  logic [7:0]    t0l_cnt_in,
  input  logic [7:0]    t1h_cnt_in,
  input  logic [7:0]    t1l_cnt_in,
  layer_code_if.slave   pix,
  output logic          bit_out,
  output logic          busy_out,
  output logic          done_out
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  localparam logic [15:0] LATCH_LD = 16'(RST_CNT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  sh_data, sh_t0h, sh_t0l, sh_t1h, sh_t1l;
  logic        sh_last;
  logic        accept, cur_bit, final_low;

  // Down-counter load value; a zero count still occupies one cycle.
  function automatic logic [15:0] phase_ld(input logic [7:0] n);
    return (n == 8'd0) ? 16'd0 : {8'd0, n - 8'd1};
  endfunction

  assign cur_bit   = sh_data[bit_idx];
  assign final_low = (state == LOW) && (cnt == 16'd0) && (bit_idx == 3'd0);
  assign pix.data_ready_out = rst_n_in && ((state == IDLE) || (final_low && !sh_last));
  assign accept    = pix.data_valid_in && pix.data_ready_out;
  assign busy_out  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HIGH;
          idx_nxt   = 3'd7;
          cnt_nxt   = phase_ld(pix.data_in[7] ? t1h_cnt_in : t0h_cnt_in);
        end
      end
      HIGH: begin
        if (cnt == 16'd0) begin
          state_nxt = LOW;
          cnt_nxt   = phase_ld(cur_bit ? sh_t1l : sh_t0l);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      LOW: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (bit_idx != 3'd0) begin
          state_nxt = HIGH;
          idx_nxt   = bit_idx - 3'd1;
          cnt_nxt   = phase_ld(sh_data[bit_idx - 3'd1] ? sh_t1h : sh_t0h);
        end else if (accept) begin
          // Next byte starts with no gap; its timing comes straight from the inputs.
          state_nxt = HIGH;
          idx_nxt   = 3'd7;
          cnt_nxt   = phase_ld(pix.data_in[7] ? t1h_cnt_in : t0h_cnt_in);
        end else if (sh_last) begin
          state_nxt = LATCH;
          cnt_nxt   = LATCH_LD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LATCH: begin
        if (cnt == 16'd0) state_nxt = IDLE;
        else              cnt_nxt   = cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      bit_idx  <= 3'd0;
      bit_out  <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= idx_nxt;
      bit_out  <= (state_nxt == HIGH);
      done_out <= (state_nxt == LATCH) && (cnt_nxt == 16'd0);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_data <= 8'd0;
      sh_last <= 1'b0;
      sh_t0h  <= 8'd0;
      sh_t0l  <= 8'd0;
      sh_t1h  <= 8'd0;
      sh_t1l  <= 8'd0;
    end else if (accept) begin
      sh_data <= pix.data_in;
      sh_last <= pix.data_last_in;
      sh_t0h  <= t0h_cnt_in;
      sh_t0l  <= t0l_cnt_in;
      sh_t1h  <= t1h_cnt_in;
      sh_t1l  <= t1l_cnt_in;
    end
  end

endmodule

// File: tb/tb_layer_code.sv
// Directed bench for the NeoPixel serializer: waveform patterns, handshake timing, latch and reset.
module tb_layer_code;
  localparam int RST = 10;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [7:0] t0h = 8'd2, t0l = 8'd5, t1h = 8'd5, t1l = 8'd2;
  logic       bit_out, busy_out, done_out;
  int         tests_run = 0;
  int         failed = 0;

  logic cap_bit  [300];
  logic cap_done [300];
  logic cap_busy [300];
  logic cap_rdy  [300];
  logic exp_bit  [300];

  layer_code_if pix();

  layer_code #(.RST_CNT(RST)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .t0h_cnt_in (t0h),
    .t0l_cnt_in (t0l),
    .t1h_cnt_in (t1h),
    .t1l_cnt_in (t1l),
    .pix        (pix),
    .bit_out    (bit_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      cap_bit[i]  = bit_out;
      cap_done[i] = done_out;
      cap_busy[i] = busy_out;
      cap_rdy[i]  = pix.data_ready_out;
    end
  endtask

  // Expected line waveform for one byte, appended at pos.
  task automatic model_byte(input logic [7:0] d, input int h0, input int l0,
                            input int h1, input int l1, inout int pos);
    for (int b = 7; b >= 0; b--) begin
      int h, l;
      h = d[b] ? h1 : h0;
      l = d[b] ? l1 : l0;
      if (h == 0) h = 1;
      if (l == 0) l = 1;
      repeat (h) begin exp_bit[pos] = 1'b1; pos++; end
      repeat (l) begin exp_bit[pos] = 1'b0; pos++; end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int k = 0;
    pix.data_valid_in = 1'b1;
    pix.data_in       = d;
    pix.data_last_in  = last;
    @(negedge clk_in);
    while (!pix.data_ready_out && k < 400) begin @(negedge clk_in); k++; end
    if (!pix.data_ready_out) begin
      tests_run++; failed++;
      $display("FAIL accept_timeout: ready=%b need 1", pix.data_ready_out);
    end
    @(posedge clk_in); #1;
    pix.data_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_out && k < 600) begin @(negedge clk_in); k++; end
    tests_run++;
    if (busy_out !== 1'b0) begin
      failed++;
      $display("FAIL %s_idle_timeout: busy=%b need 0", name, busy_out);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      pix.data_valid_in = ~pix.data_valid_in;
      #1;
      if (bit_out !== 1'b0 || pix.data_ready_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failed++;
      $display("FAIL reset_hold: %0d bad samples, bit=%b rdy=%b busy=%b need 0", bad, bit_out, pix.data_ready_out, busy_out);
    end
    pix.data_valid_in = 1'b0;
    rst_n_in = 1'b1;
    @(negedge clk_in);
    tests_run++;
    if (pix.data_ready_out !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %b need 1", pix.data_ready_out);
    end
  endtask

  task automatic compare_pattern(input string name, input int n);
    int errs = 0, first = -1;
    for (int i = 0; i < n; i++)
      if (cap_bit[i] !== exp_bit[i]) begin errs++; if (first < 0) first = i; end
    tests_run++;
    if (errs != 0) begin
      failed++;
      $display("FAIL %s_pattern: %0d bad cycles, first at %0d got %b need %b", name, errs, first, cap_bit[first], exp_bit[first]);
    end
  endtask

  task automatic check_latch(input string name, input int start);
    int dn = 0;
    for (int i = 0; i < start + RST + 1; i++) if (cap_done[i] === 1'b1) dn++;
    tests_run++;
    if (dn != 1 || cap_done[start + RST - 1] !== 1'b1) begin
      failed++;
      $display("FAIL %s_done: pulses=%0d at_end=%b need 1 pulse at cycle %0d", name, dn, cap_done[start + RST - 1], start + RST - 1);
    end
    tests_run++;
    if (cap_busy[start + RST - 1] !== 1'b1 || cap_busy[start + RST] !== 1'b0) begin
      failed++;
      $display("FAIL %s_busy_end: busy last-latch=%b after=%b need 1,0", name, cap_busy[start + RST - 1], cap_busy[start + RST]);
    end
  endtask

  task automatic test_single_byte();
    int pos = 0, rdy = 0;
    t0h = 8'd2; t0l = 8'd5; t1h = 8'd5; t1l = 8'd2;
    model_byte(8'hA5, 2, 5, 5, 2, pos);
    for (int i = 0; i < RST; i++) begin exp_bit[pos] = 1'b0; pos++; end
    send_byte(8'hA5, 1'b1);
    capture(56 + RST + 1);
    compare_pattern("single", 56 + RST);
    check_latch("single", 56);
    for (int i = 0; i < 56 + RST; i++) if (cap_rdy[i] === 1'b1) rdy++;
    tests_run++;
    if (rdy != 0) begin
      failed++;
      $display("FAIL single_ready_low: ready high %0d cycles, need 0", rdy);
    end
  endtask

  task automatic test_back_to_back();
    int pos = 0, rdy = 0;
    model_byte(8'hFF, 2, 5, 5, 2, pos);
    model_byte(8'h00, 2, 5, 5, 2, pos);
    for (int i = 0; i < RST; i++) begin exp_bit[pos] = 1'b0; pos++; end
    pix.data_valid_in = 1'b1; pix.data_in = 8'hFF; pix.data_last_in = 1'b0;
    @(posedge clk_in); #1;
    pix.data_in = 8'h00; pix.data_last_in = 1'b1;
    for (int i = 0; i < 112 + RST + 1; i++) begin
      @(negedge clk_in);
      cap_bit[i] = bit_out; cap_done[i] = done_out;
      cap_busy[i] = busy_out; cap_rdy[i] = pix.data_ready_out;
      if (i == 56) pix.data_valid_in = 1'b0;
    end
    compare_pattern("b2b", 112 + RST);
    for (int i = 0; i < 112 + RST; i++) if (cap_rdy[i] === 1'b1) rdy++;
    tests_run++;
    if (rdy != 1 || cap_rdy[55] !== 1'b1) begin
      failed++;
      $display("FAIL b2b_ready: high %0d cycles, at 55=%b need exactly cycle 55", rdy, cap_rdy[55]);
    end
    tests_run++;
    if (cap_bit[55] !== 1'b0 || cap_bit[56] !== 1'b1) begin
      failed++;
      $display("FAIL b2b_seam: bit[55]=%b bit[56]=%b need 0,1", cap_bit[55], cap_bit[56]);
    end
    check_latch("b2b", 112);
  endtask

  task automatic test_zero_counts();
    int pos = 0;
    t0h = 8'd0; t0l = 8'd0; t1h = 8'd0; t1l = 8'd0;
    for (int i = 0; i < 8; i++) begin exp_bit[pos] = 1'b1; exp_bit[pos + 1] = 1'b0; pos += 2; end
    for (int i = 0; i < RST; i++) begin exp_bit[pos] = 1'b0; pos++; end
    send_byte(8'h80, 1'b1);
    capture(16 + RST + 1);
    compare_pattern("zero", 16 + RST);
    check_latch("zero", 16);
    t0h = 8'd2; t0l = 8'd5; t1h = 8'd5; t1l = 8'd2;
  endtask

  task automatic test_config_change();
    int pos = 0, errs = 0;
    model_byte(8'hFF, 2, 5, 5, 2, pos);
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < 57; i++) begin
      @(negedge clk_in);
      cap_bit[i] = bit_out; cap_busy[i] = busy_out;
      if (i == 30) t1h = 8'd20;
    end
    compare_pattern("cfg_old", 56);
    tests_run++;
    if (cap_busy[56] !== 1'b0) begin
      failed++;
      $display("FAIL cfg_rest_idle: busy=%b need 0", cap_busy[56]);
    end
    send_byte(8'hFF, 1'b1);
    capture(22);
    for (int i = 0; i < 22; i++) if (cap_bit[i] !== (i < 20)) errs++;
    tests_run++;
    if (errs != 0) begin
      failed++;
      $display("FAIL cfg_new_t1h: %0d bad cycles, bit[19]=%b bit[20]=%b need 1,0", errs, cap_bit[19], cap_bit[20]);
    end
    wait_idle("cfg");
    t1h = 8'd5;
  endtask

  task automatic test_reset_mid();
    int dn = 0, errs = 0;
    send_byte(8'hA5, 1'b1);
    repeat (60) @(negedge clk_in);
    tests_run++;
    if (busy_out !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_in_latch: busy=%b need 1", busy_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    tests_run++;
    if (bit_out !== 1'b0 || busy_out !== 1'b0 || pix.data_ready_out !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_async: bit=%b busy=%b rdy=%b need 0,0,0", bit_out, busy_out, pix.data_ready_out);
    end
    repeat (3) begin @(negedge clk_in); if (done_out !== 1'b0) dn++; end
    rst_n_in = 1'b1;
    repeat (15) begin @(negedge clk_in); if (done_out !== 1'b0 || busy_out !== 1'b0) dn++; end
    tests_run++;
    if (dn != 0) begin
      failed++;
      $display("FAIL rstmid_no_done: %0d samples with done/busy high, need 0", dn);
    end
    send_byte(8'h01, 1'b1);
    capture(7);
    for (int i = 0; i < 7; i++) if (cap_bit[i] !== (i < 2)) errs++;
    tests_run++;
    if (errs != 0) begin
      failed++;
      $display("FAIL rstmid_restart: %0d bad cycles, bit[0]=%b bit[2]=%b need 1,0", errs, cap_bit[0], cap_bit[2]);
    end
    wait_idle("rstmid");
  endtask

  initial begin
    pix.data_valid_in = 1'b0;
    pix.data_last_in  = 1'b0;
    pix.data_in       = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_zero_counts();
    test_config_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
